// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_arb_pkg;

  // Which requester issued a memory access.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_BYP = 1'b1
  } owner_e;

  // One read-tag pipeline entry: was a read issued, and by whom.
  typedef struct packed {
    logic   rd;
    owner_e owner;
  } tag_t;

  localparam int unsigned DEF_MAX_WAIT = 4;
  localparam int unsigned DEF_READ_LAT = 1;
  localparam int unsigned WAIT_W       = 4;

endpackage

// File: rtl/dmem_arb_tagpipe.sv
// READ_LAT-deep shift register of read tags; holds while memory stalls.
module dmem_arb_tagpipe
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_READ_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  input  tag_t push_tag,
  output tag_t pop_tag
);

  tag_t pipe_q [DEPTH];
  tag_t pipe_d [DEPTH];

  // Next-state: shift one slot per non-stalled cycle, otherwise keep contents.
  always_comb begin
    pipe_d[0] = hold ? pipe_q[0] : push_tag;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = hold ? pipe_q[i] : pipe_q[i-1];
    end
  end

  // Tag storage; asynchronous clear drops every outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign pop_tag = pipe_q[DEPTH-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the CPU (priority) and the bypass
// master, with a starvation counter that forces a bypass grant and a tag
// pipeline that steers read responses back to the bypass master.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
  parameter int unsigned READ_LAT = DEF_READ_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_we,
  input  logic        cpu_re,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_stall,
  input  logic        byp_valid,
  output logic        byp_ready,
  input  logic [31:0] byp_addr,
  input  logic [3:0]  byp_we,
  input  logic        byp_re,
  input  logic [31:0] byp_din,
  output logic [31:0] byp_rdata,
  output logic        byp_rvalid,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic        mem_re,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_stall
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_L = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              force_byp;
  logic              grant_cpu;
  logic              grant_byp;
  tag_t              push_tag;
  tag_t              out_tag;

  // Grant selection; rst gating keeps every grant low while reset is held.
  always_comb begin
    force_byp = byp_valid && (wait_cnt_q == MAX_WAIT_L);
    grant_cpu = rst && cpu_req && !force_byp && !mem_stall;
    grant_byp = rst && byp_valid && !grant_cpu && !mem_stall;
    cpu_stall = rst && cpu_req && !grant_cpu;
    byp_ready = grant_byp;
  end

  // Port mux; with no grant the address/data lines simply follow the CPU.
  always_comb begin
    mem_addr = cpu_addr;
    mem_din  = cpu_din;
    mem_we   = '0;
    mem_re   = 1'b0;
    if (grant_cpu) begin
      mem_we = cpu_we;
      mem_re = cpu_re;
    end else if (grant_byp) begin
      mem_addr = byp_addr;
      mem_din  = byp_din;
      mem_we   = byp_we;
      mem_re   = byp_re;
    end
  end

  // Starvation counter next-state: frozen on stall, cleared on grant/idle.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!mem_stall) begin
      if (!byp_valid || grant_byp) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q < MAX_WAIT_L) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Tag for this cycle's access: only granted reads produce a response.
  always_comb begin
    push_tag.rd    = (grant_cpu || grant_byp) && mem_re;
    push_tag.owner = grant_byp ? OWN_BYP : OWN_CPU;
  end

  dmem_arb_tagpipe #(
    .DEPTH (READ_LAT)
  ) u_tagpipe (
    .clk      (clk),
    .rst_n    (rst),
    .hold     (mem_stall),
    .push_tag (push_tag),
    .pop_tag  (out_tag)
  );

  // Response routing; the CPU samples read data on its own schedule.
  always_comb begin
    cpu_dout   = mem_dout;
    byp_rdata  = mem_dout;
    byp_rvalid = out_tag.rd && (out_tag.owner == OWN_BYP) && !mem_stall;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed scenarios then random traffic.
module tb_dmem_port_arbiter;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned READ_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req, cpu_re, byp_valid, byp_re, mem_stall;
  logic [31:0] cpu_addr, cpu_din, byp_addr, byp_din, mem_dout;
  logic [3:0]  cpu_we, byp_we;
  logic [31:0] cpu_dout, byp_rdata, mem_addr, mem_din;
  logic        cpu_stall, byp_ready, byp_rvalid, mem_re;
  logic [3:0]  mem_we;

  dmem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .byp_valid(byp_valid), .byp_ready(byp_ready), .byp_addr(byp_addr),
    .byp_we(byp_we), .byp_re(byp_re), .byp_din(byp_din),
    .byp_rdata(byp_rdata), .byp_rvalid(byp_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_din;
    logic        byp_valid;
    logic [31:0] byp_addr;
    logic [3:0]  byp_we;
    logic        byp_re;
    logic [31:0] byp_din;
    logic        mem_stall;
  } stim_t;

  typedef struct {
    bit          in_rst;
    bit          stall;
    int unsigned nst;
    logic        cpu_stall;
    logic        byp_ready;
    logic [3:0]  we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] din;
  } port_t;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } rd_t;

  port_t pq[$];
  rd_t   rdq[$];
  stim_t nx;

  int          total = 0;
  int          bad   = 0;
  int          wcnt  = 0;
  int unsigned nst   = 0;
  bit          last_gb = 0;

  // Memory contents as a function of address, so returned data identifies the read.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  // Environment memory: READ_LAT-cycle read pipe that freezes while stalled.
  logic [31:0] env_pipe [READ_LAT];
  always @(posedge clk) begin
    if (!mem_stall) begin
      env_pipe[0] <= mem_re ? mem_fn(mem_addr) : $urandom;
      for (int i = 1; i < READ_LAT; i++) env_pipe[i] <= env_pipe[i-1];
    end
  end
  assign mem_dout = env_pipe[READ_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply nx, optionally hold reset this cycle, then model it.
  task automatic step(input bit rst_low);
    port_t e;
    bit    frc, gc, gb;
    @(negedge clk);
    cpu_req = nx.cpu_req; cpu_addr = nx.cpu_addr; cpu_we = nx.cpu_we;
    cpu_re = nx.cpu_re; cpu_din = nx.cpu_din;
    byp_valid = nx.byp_valid; byp_addr = nx.byp_addr; byp_we = nx.byp_we;
    byp_re = nx.byp_re; byp_din = nx.byp_din; mem_stall = nx.mem_stall;
    if (rst_low) begin
      #1 rst = 1'b0;
    end else begin
      rst = 1'b1;
    end
    #1;
    e.in_rst = rst_low;
    e.stall  = nx.mem_stall;
    e.nst    = nst;
    e.addr   = nx.cpu_addr;
    e.din    = nx.cpu_din;
    e.we     = 4'h0;
    e.re     = 1'b0;
    if (rst_low) begin
      e.cpu_stall = 1'b0;
      e.byp_ready = 1'b0;
      rdq.delete();
      wcnt    = 0;
      last_gb = 0;
    end else begin
      frc = nx.byp_valid && (wcnt == MAX_WAIT);
      gc  = nx.cpu_req && !frc && !nx.mem_stall;
      gb  = nx.byp_valid && !gc && !nx.mem_stall;
      e.cpu_stall = nx.cpu_req && !gc;
      e.byp_ready = gb;
      if (gc) begin
        e.we = nx.cpu_we; e.re = nx.cpu_re;
      end else if (gb) begin
        e.we = nx.byp_we; e.re = nx.byp_re; e.addr = nx.byp_addr; e.din = nx.byp_din;
      end
      if (gb && nx.byp_re) rdq.push_back('{due: nst + READ_LAT, data: mem_fn(nx.byp_addr)});
      if (!nx.mem_stall) begin
        if (!nx.byp_valid || gb) wcnt = 0;
        else if (wcnt < MAX_WAIT) wcnt = wcnt + 1;
        nst++;
      end
      last_gb = gb;
    end
    pq.push_back(e);
  endtask

  // Monitor: pops one expectation per cycle and checks the DUT before the edge.
  initial begin
    port_t e;
    bit    exp_rv;
    forever begin
      @(negedge clk);
      #4;
      if (pq.size() > 0) begin
        e = pq.pop_front();
        chk("cpu_stall", cpu_stall, e.cpu_stall);
        chk("byp_ready", byp_ready, e.byp_ready);
        chk("mem_we", mem_we, e.we);
        chk("mem_re", mem_re, e.re);
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_din", mem_din, e.din);
        chk("cpu_dout", cpu_dout, mem_dout);
        exp_rv = 0;
        if (!e.in_rst && !e.stall) exp_rv = (rdq.size() > 0) && (rdq[0].due == e.nst);
        chk("byp_rvalid", byp_rvalid, exp_rv);
        if (exp_rv) begin
          if (byp_rvalid) chk("byp_rdata", byp_rdata, rdq[0].data);
          void'(rdq.pop_front());
        end
      end
    end
  end

  task automatic idle();
    nx = '{default: '0};
  endtask

  task automatic rand_stim();
    bit hold_byp;
    hold_byp = nx.byp_valid && !last_gb;
    nx.cpu_req  = ($urandom_range(3) != 0);
    nx.cpu_addr = $urandom;
    nx.cpu_we   = ($urandom_range(1) != 0) ? 4'($urandom) : 4'h0;
    nx.cpu_re   = ($urandom_range(1) != 0);
    nx.cpu_din  = $urandom;
    nx.mem_stall = ($urandom_range(5) == 0);
    if (!hold_byp) begin
      nx.byp_valid = ($urandom_range(2) != 0);
      nx.byp_addr  = $urandom;
      nx.byp_we    = ($urandom_range(1) != 0) ? 4'($urandom) : 4'h0;
      nx.byp_re    = (nx.byp_we == 4'h0) ? 1'b1 : ($urandom_range(1) != 0);
      nx.byp_din   = $urandom;
    end
  endtask

  initial begin
    idle();
    // Reset held for two cycles while a bypass request is pending.
    nx.cpu_req = 1; nx.byp_valid = 1; nx.byp_re = 1; nx.byp_we = 4'h3;
    step(1); step(1);
    idle(); step(0);

    // CPU only, reads at 0x100.
    nx.cpu_req = 1; nx.cpu_re = 1; nx.cpu_addr = 32'h100;
    repeat (3) step(0);

    // Bypass write alone.
    idle();
    nx.byp_valid = 1; nx.byp_we = 4'hF; nx.byp_addr = 32'h8000_0000; nx.byp_din = 32'hDEAD_BEEF;
    step(0);
    idle(); step(0);

    // Starvation: both requesting; bypass forced through on the fifth cycle.
    nx.cpu_req = 1; nx.cpu_we = 4'hF; nx.cpu_addr = 32'h44; nx.cpu_din = 32'hA5A5_0001;
    nx.byp_valid = 1; nx.byp_re = 1; nx.byp_addr = 32'h40;
    repeat (7) step(0);
    idle(); step(0);

    // Bypass read followed by a CPU read.
    nx.byp_valid = 1; nx.byp_re = 1; nx.byp_addr = 32'h200; step(0);
    idle(); nx.cpu_req = 1; nx.cpu_re = 1; nx.cpu_addr = 32'h300; step(0);
    idle(); step(0); step(0);

    // Bypass read, then stall while both request with the counter at 2.
    nx.byp_valid = 1; nx.byp_re = 1; nx.byp_addr = 32'h600; step(0);
    nx.cpu_req = 1; nx.cpu_re = 1; nx.cpu_addr = 32'h700; nx.byp_addr = 32'h640;
    repeat (2) step(0);
    nx.mem_stall = 1; repeat (3) step(0);
    nx.mem_stall = 0; step(0);
    idle(); step(0);

    // Asynchronous reset with a bypass read in flight.
    nx.byp_valid = 1; nx.byp_re = 1; nx.byp_addr = 32'h900; step(0);
    nx.cpu_req = 1; nx.byp_addr = 32'h940; step(1);
    idle(); repeat (3) step(0);

    // Random traffic with one mid-run reset.
    for (int i = 0; i < 600; i++) begin
      rand_stim();
      step(i == 300);
    end
    idle(); repeat (4) step(0);
    @(negedge clk); #6;
    chk("rd_queue_drained", rdq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
